// File: rtl/ascon_perm_engine_pkg.sv
// Shared types, constants and helpers for the Ascon permutation engine.
package ascon_perm_engine_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 5;
  localparam int unsigned RND_W     = 4;
  localparam int unsigned RC_W      = 8;

  // Word 0 is x0, word 4 is x4.
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;

  // Encoding 2'b11 is not listed; it falls back to the 12-round job.
  typedef enum logic [1:0] {
    MODE_P12 = 2'b00,
    MODE_P8  = 2'b01,
    MODE_P6  = 2'b10
  } mode_e;

  // Round constant for round idx: high nibble 15-idx, low nibble idx.
  function automatic logic [RC_W-1:0] round_const(input logic [RND_W-1:0] idx);
    return {4'(4'd15 - idx), idx};
  endfunction

  // Number of rounds a job runs for a given mode.
  function automatic logic [RND_W-1:0] mode_rounds(input logic [1:0] mode);
    logic [RND_W-1:0] rounds;
    case (mode)
      MODE_P8: rounds = 4'd8;
      MODE_P6: rounds = 4'd6;
      default: rounds = 4'd12;
    endcase
    return rounds;
  endfunction

  // 64-bit rotate right by a constant amount.
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned     n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

endpackage

// File: rtl/ascon_perm_engine_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear diffusion.
module ascon_perm_engine_round
  import ascon_perm_engine_pkg::*;
(
  input  type_state        i_state,
  input  logic [RND_W-1:0] i_round,
  output type_state        o_state
);

  type_state w_const;
  type_state w_sbox;

  // Round constant is folded into the low byte of x2.
  always_comb begin
    w_const                = i_state;
    w_const[2][RC_W-1:0]   = i_state[2][RC_W-1:0] ^ round_const(i_round);
  end

  // Bit-sliced 5-bit S-box across the five words.
  always_comb begin : sbox
    logic [WORD_W-1:0] x0, x1, x2, x3, x4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    x0 = w_const[0] ^ w_const[4];
    x1 = w_const[1];
    x2 = w_const[2] ^ w_const[1];
    x3 = w_const[3];
    x4 = w_const[4] ^ w_const[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    w_sbox = {x4, x3, x2, x1, x0};
  end

  // Per-word linear diffusion with word-specific rotation pairs.
  assign o_state[0] = w_sbox[0] ^ rotr(w_sbox[0], 19) ^ rotr(w_sbox[0], 28);
  assign o_state[1] = w_sbox[1] ^ rotr(w_sbox[1], 61) ^ rotr(w_sbox[1], 39);
  assign o_state[2] = w_sbox[2] ^ rotr(w_sbox[2],  1) ^ rotr(w_sbox[2],  6);
  assign o_state[3] = w_sbox[3] ^ rotr(w_sbox[3], 10) ^ rotr(w_sbox[3], 17);
  assign o_state[4] = w_sbox[4] ^ rotr(w_sbox[4],  7) ^ rotr(w_sbox[4], 41);

endmodule

// File: rtl/ascon_perm_engine.sv
// Iterative Ascon p^a engine: UNROLL rounds per clock, 12/8/6 rounds per job.
module ascon_perm_engine
  import ascon_perm_engine_pkg::*;
#(
  parameter int unsigned UNROLL    = 1,
  parameter int unsigned ROUND_MAX = 12
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output type_state  state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  if (!((UNROLL == 1) || (UNROLL == 2))) begin : g_unroll_check
    $error("ascon_perm_engine: UNROLL must be 1 or 2");
  end

  logic [1:0]       r_fsm;
  logic [RND_W-1:0] r_round;
  type_state        r_data;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_fsm_next;
  logic [RND_W-1:0] w_round_next;
  type_state        w_data_next;
  logic             w_ready_next;
  logic             w_busy_next;
  logic             w_done_next;
  type_state        w_chain [UNROLL+1];

  // Chain UNROLL rounds with consecutive indices off the current counter.
  assign w_chain[0] = r_data;
  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    ascon_perm_engine_round u_round (
      .i_state (w_chain[g]),
      .i_round (r_round + RND_W'(g)),
      .o_state (w_chain[g+1])
    );
  end

  // State, counter, data and registered status flags.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_fsm   <= ST_IDLE;
      r_round <= '0;
      r_data  <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_round <= w_round_next;
      r_data  <= w_data_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next-state logic; status flags are decoded from the next state so they line up with it.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_round_next = r_round;
    w_data_next  = r_data;
    case (r_fsm)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          w_fsm_next   = ST_RUN;
          w_round_next = RND_W'(ROUND_MAX) - mode_rounds(mode_i);
          w_data_next  = state_i;
        end else begin
          w_fsm_next   = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_data_next  = w_chain[UNROLL];
        w_round_next = r_round + RND_W'(UNROLL);
        if (r_round == RND_W'(ROUND_MAX - UNROLL)) begin
          w_fsm_next = ST_DONE;
        end
      end
      default: begin
        w_fsm_next = ST_IDLE;
      end
    endcase
    w_ready_next = (w_fsm_next != ST_RUN);
    w_busy_next  = (w_fsm_next == ST_RUN);
    w_done_next  = (w_fsm_next == ST_DONE);
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign state_o = r_data;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Self-checking bench for ascon_perm_engine with UNROLL=1 and UNROLL=2 instances.
module tb_ascon_perm_engine;
  import ascon_perm_engine_pkg::*;

  typedef struct {
    type_state st;
    int        cyc;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    type_state  st;
    int         lat1;
    int         lat2;
  } vec_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [12] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [1:0] mode1 = 2'b00, mode2 = 2'b00;
  type_state  st1 = '0, st2 = '0;
  logic       rdy1, busy1, done1, rdy2, busy2, done2;
  type_state  out1, out2;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  type_state last1 = '0;
  vec_t vecs[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascon_perm_engine #(.UNROLL(1), .ROUND_MAX(12)) u_dut1 (
    .clock_i(clk), .reset_i(rst), .start_i(start1), .mode_i(mode1), .state_i(st1),
    .ready_o(rdy1), .busy_o(busy1), .done_o(done1), .state_o(out1));

  ascon_perm_engine #(.UNROLL(2), .ROUND_MAX(12)) u_dut2 (
    .clock_i(clk), .reset_i(rst), .start_i(start2), .mode_i(mode2), .state_i(st2),
    .ready_o(rdy2), .busy_o(busy2), .done_o(done2), .state_o(out2));

  // Reference permutation: table S-box per bit column, double-width rotate.
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic int first_round(input logic [1:0] m);
    case (m)
      2'b01:   return 4;
      2'b10:   return 6;
      default: return 0;
    endcase
  endfunction

  function automatic type_state ref_perm(input type_state s_in, input int first);
    type_state  s;
    logic [4:0] col;
    logic [4:0] sub;
    s = s_in;
    for (int i = first; i < 12; i++) begin
      s[2][7:0] = s[2][7:0] ^ RC[i];
      for (int j = 0; j < 64; j++) begin
        col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
        sub = SBOX[col];
        s[0][j] = sub[4];
        s[1][j] = sub[3];
        s[2][j] = sub[2];
        s[3][j] = sub[1];
        s[4][j] = sub[0];
      end
      s[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
      s[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
      s[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
      s[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
      s[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
    end
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom(), $urandom()};
    return s;
  endfunction

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input type_state act, input type_state exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int waited);
    n_checks++;
    n_errors++;
    $display("FAIL %s: waited %0d cycles without the required event", name, waited);
  endtask

  // Scoreboard pop for the UNROLL=1 instance.
  always @(posedge clk) begin
    #1;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk_bit("dut1_unexpected_done", done1, 1'b0);
      end else begin
        e1 = q1.pop_front();
        chk_state("dut1_result", out1, e1.st);
        chk_int("dut1_done_cycle", cyc, e1.cyc);
        chk_bit("dut1_ready_in_done", rdy1, 1'b1);
        last1 = e1.st;
      end
    end
  end

  // Scoreboard pop for the UNROLL=2 instance.
  always @(posedge clk) begin
    #1;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        chk_bit("dut2_unexpected_done", done2, 1'b0);
      end else begin
        e2 = q2.pop_front();
        chk_state("dut2_result", out2, e2.st);
        chk_int("dut2_done_cycle", cyc, e2.cyc);
        chk_bit("dut2_busy_in_done", busy2, 1'b0);
      end
    end
  end

  // Drive a job, leave start high, and push the expectation at the load edge.
  task automatic launch(input int which, input logic [1:0] m, input type_state s, input int lat);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    if (which == 1) begin
      mode1 = m; st1 = s; start1 = 1'b1;
    end else begin
      mode2 = m; st2 = s; start2 = 1'b1;
    end
    while (((which == 1) ? rdy1 : rdy2) !== 1'b1 && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 64) begin
      fail_now("launch_ready_timeout", waited);
      return;
    end
    @(posedge clk);
    #1;
    e.st  = ref_perm(s, first_round(m));
    e.cyc = cyc + lat - 1;
    if (which == 1) begin
      q1.push_back(e);
      chk_bit("dut1_busy_after_load", busy1, 1'b1);
      chk_bit("dut1_ready_after_load", rdy1, 1'b0);
    end else begin
      q2.push_back(e);
      chk_bit("dut2_busy_after_load", busy2, 1'b1);
      chk_bit("dut2_ready_after_load", rdy2, 1'b0);
    end
  endtask

  task automatic drop(input int which);
    @(negedge clk);
    if (which == 1) start1 = 1'b0;
    else            start2 = 1'b0;
  endtask

  task automatic drain(input int which);
    int waited;
    waited = 0;
    while (((which == 1) ? q1.size() : q2.size()) != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    if (waited >= 200) fail_now("drain_timeout", waited);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    type_state iv;
    iv    = '0;
    iv[0] = 64'h80400c0600000000;
    vecs[0] = '{mode: 2'b00, st: iv,           lat1: 13, lat2: 7};
    vecs[1] = '{mode: 2'b01, st: rand_state(), lat1: 9,  lat2: 5};
    vecs[2] = '{mode: 2'b10, st: rand_state(), lat1: 7,  lat2: 4};
    vecs[3] = '{mode: 2'b11, st: iv,           lat1: 13, lat2: 7};
    vecs[4] = '{mode: 2'b00, st: rand_state(), lat1: 13, lat2: 7};
    vecs[5] = '{mode: 2'b11, st: vecs[4].st,   lat1: 13, lat2: 7};

    // Reset values.
    #12;
    chk_bit("rst_ready1", rdy1, 1'b1);
    chk_bit("rst_busy1", busy1, 1'b0);
    chk_bit("rst_done1", done1, 1'b0);
    chk_state("rst_state1", out1, '0);
    chk_bit("rst_ready2", rdy2, 1'b1);
    chk_state("rst_state2", out2, '0);
    @(negedge clk);
    rst = 1'b0;

    // Table of single jobs on both unroll factors.
    foreach (vecs[i]) begin
      launch(1, vecs[i].mode, vecs[i].st, vecs[i].lat1);
      drop(1);
      drain(1);
      launch(2, vecs[i].mode, vecs[i].st, vecs[i].lat2);
      drop(2);
      drain(2);
    end

    // Back-to-back: start held high across three jobs, inputs change during RUN.
    launch(1, 2'b00, rand_state(), 13);
    launch(1, 2'b01, rand_state(), 9);
    launch(1, 2'b10, rand_state(), 7);
    drop(1);
    drain(1);
    launch(2, 2'b10, rand_state(), 4);
    launch(2, 2'b01, rand_state(), 5);
    launch(2, 2'b00, rand_state(), 7);
    drop(2);
    drain(2);

    // A start pulse mid-RUN must be ignored.
    launch(1, 2'b00, vecs[4].st, 13);
    drop(1);
    repeat (3) @(negedge clk);
    chk_bit("midrun_busy1", busy1, 1'b1);
    st1 = rand_state(); mode1 = 2'b10; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    drain(1);

    // Result holds while inputs wander with start low.
    for (int k = 0; k < 5; k++) begin
      st1   = rand_state();
      mode1 = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk_state("held_state1", out1, last1);
      chk_bit("held_ready1", rdy1, 1'b1);
    end

    // Asynchronous reset mid-job aborts it with no done pulse.
    launch(1, 2'b00, iv, 13);
    drop(1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_state("midrst_state1", out1, '0);
    chk_bit("midrst_ready1", rdy1, 1'b1);
    chk_bit("midrst_busy1", busy1, 1'b0);
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_bit("postrst_busy1", busy1, 1'b0);
    chk_bit("postrst_done1", done1, 1'b0);
    launch(1, 2'b00, iv, 13);
    drop(1);
    drain(1);

    chk_int("dut1_queue_empty", q1.size(), 0);
    chk_int("dut2_queue_empty", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ascon_perm_engine.md
Name: ascon_perm_engine

Overview:
- Iterative Ascon permutation core. Applies p^a to a 320-bit state.
- Round count a is 12, 8 or 6, selected per job.
- UNROLL rounds (constant addition, S-box layer, linear diffusion) are computed per clock.
- Sits between the Ascon mode FSM (init/absorb/squeeze/finalise) and the state register file; replaces per-round sequencing in the top-level FSM.

Parameters:
- UNROLL, 1: rounds per clock. Legal values are 1 and 2, enforced by elaboration-time assertion.
- ROUND_MAX, 12: total round-constant schedule length.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  job request; sampled only when ready_o=1
- mode_i  in  2  round count: 00=12, 01=8, 10=6, 11 treated as 12
- state_i  in  type_state (5x64)  input state, captured with start_i
- ready_o  out  1  engine can accept start_i this cycle
- busy_o  out  1  rounds in progress
- done_o  out  1  one-cycle pulse; state_o holds the p^a result
- state_o  out  type_state (5x64)  working/result state register

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE.
  - state_o=0, ready_o=1, busy_o=0, done_o=0.
  - Round counter is cleared.
  - Reset asserted mid-job aborts the job immediately; no done_o is issued.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - ready_o=1.
  - start_i=1 at a rising edge: load state_i into the state register, set counter r=ROUND_MAX-a, go to RUN.
  - No rounds are applied on the load edge.
- RUN:
  - busy_o=1, ready_o=0.
  - Each edge applies rounds r..r+UNROLL-1 combinationally chained, then r+=UNROLL.
  - When r reaches ROUND_MAX on that edge, go to DONE.
  - start_i is ignored while in RUN.
- DONE:
  - Lasts exactly one cycle with done_o=1, ready_o=1, busy_o=0.
  - start_i=1 here is accepted, giving back-to-back jobs: load and go to RUN.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; done_o is high in the cycle after edge E0 + a/UNROLL.
  - UNROLL=1: a=12 gives 13 cycles, a=8 gives 9, a=6 gives 7.
  - UNROLL=2: halve the compute part, i.e. 7/5/4 cycles.
- state_o is stable from DONE until the next load edge. It is visible but not meaningful during RUN.
- Round i (0..11):
  - Constant addition: x2[7:0] ^= {4'(15-i), 4'(i)}. Schedule is 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B.
  - Substitution: Ascon 5-bit S-box applied bit-sliced across x0..x4.
  - Linear diffusion: xk ^= rotr(xk,a) ^ rotr(xk,b), with (a,b) = x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
- mode_i is sampled only on the load edge. Changing it during RUN has no effect.
- mode_i=11 behaves exactly as 00 (a=12, starting constant 0xF0).
- All a values are multiples of UNROLL, so there are no partial cycles.
- Counter width is 4 bits. It never wraps: the RUN exit compare happens before any increment past 12.

Decomposition:
- ascon_pack additions:
  - type_state (array of 5 x 64-bit words).
  - Round-constant function or 12-entry constant array.
  - Mode encoding enum: MODE_P12, MODE_P8, MODE_P6.
  - Function mapping mode to start index.
- Sub-module ascon_round, combinational:
  - Inputs: state and 4-bit round index. Output: next state.
  - Internally chains constant addition, S-box and linear diffusion.
  - Instantiated UNROLL times in a generate loop with indices r and r+1.
- Engine RTL holds only the FSM, the counter, the state register and the output decodes.

Test Plan:
- Reset during RUN:
  - Stimulus: start (a=12, UNROLL=1), assert reset_i at cycle 5 for 1 cycle.
  - Required: state_o=0 and ready_o=1 asynchronously; no done_o pulse; a later fresh job produces the correct result.
- p12 latency and result, UNROLL=1:
  - Stimulus: state_i = Ascon-128 init word {0x80400c0600000000, 0, 0, 0, 0}, mode_i=00.
  - Required: done_o high exactly in cycle 13 after the start edge; state_o equals the C reference model p12 output.
- Mode and unroll coverage:
  - Stimulus: random state, mode_i = 01 and 10, each with UNROLL=1 and UNROLL=2.
  - Required: done_o at cycles 9/7 (UNROLL=1) and 5/4 (UNROLL=2); results match model p8/p6.
- Mode 11:
  - Stimulus: mode_i=11 with the same state as a mode 00 run.
  - Required: identical result and latency to mode 00.
- Back-to-back and ignored start:
  - Stimulus: start_i held high continuously for 3 jobs; also pulse start_i during RUN.
  - Required: jobs chain with one DONE cycle between them; each result is correct; the mid-RUN start neither restarts nor corrupts the job.
- Held inputs:
  - Stimulus: change state_i and mode_i during RUN and after DONE.
  - Required: state_o unaffected until the next accepted start.
